// File: rtl/rv32_pkg.sv
// Shared RV32 core types: ALU op codes and the M-extension sequencer bundles.
// Provides mdu_state_t, rv32_mdu_req_t, rv32_mdu_resp_t and op-class helpers.
package rv32_pkg;

  localparam logic [5:0] ALU_OP_ADD    = 6'h00;
  localparam logic [5:0] ALU_OP_SUB    = 6'h01;
  localparam logic [5:0] ALU_OP_AND    = 6'h02;
  localparam logic [5:0] ALU_OP_OR     = 6'h03;
  localparam logic [5:0] ALU_OP_XOR    = 6'h04;
  localparam logic [5:0] ALU_OP_SLL    = 6'h05;
  localparam logic [5:0] ALU_OP_MUL    = 6'h20;
  localparam logic [5:0] ALU_OP_MULH   = 6'h21;
  localparam logic [5:0] ALU_OP_MULHSU = 6'h22;
  localparam logic [5:0] ALU_OP_MULHU  = 6'h23;
  localparam logic [5:0] ALU_OP_DIV    = 6'h24;
  localparam logic [5:0] ALU_OP_DIVU   = 6'h25;
  localparam logic [5:0] ALU_OP_REM    = 6'h26;
  localparam logic [5:0] ALU_OP_REMU   = 6'h27;

  localparam int MDU_DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } mdu_state_t;

  typedef struct packed {
    logic [5:0]  alu_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } rv32_mdu_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } rv32_mdu_resp_t;

  function automatic logic is_mdu_op(input logic [5:0] op);
    return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op >= ALU_OP_DIV) && (op <= ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration, purely combinational.
// Ports: rem_in/quo_in/divisor in; rem_out/quo_out out.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Partial remainder is 33 bits after the shift; the subtract result
  // always fits in XLEN bits whenever it is taken.
  assign w_shift = {rem_in, quo_in[XLEN-1]};
  assign w_ge    = w_shift >= {1'b0, divisor};
  assign w_diff  = w_shift[XLEN-1:0] - divisor;
  assign rem_out = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], w_ge};

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// M-extension sequencer: MUL* via pipelined product, DIV/REM via 32-step
// restoring loop. Ports: clk, rst_n, req_* (valid/ready/alu_op/rs1/rs2/rd),
// flush, resp_* (valid/ready/data/rd), stall. Option: MULDIV_EARLY_OUT_EN.
module ex_muldiv_ctrl
  import rv32_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_alu_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            stall
);

  mdu_state_t            r_state;
  rv32_mdu_req_t         r_req;
  rv32_mdu_resp_t        r_resp;
  logic                  r_resp_valid;
  logic [XLEN-1:0]       r_rem;
  logic [XLEN-1:0]       r_quo;
  logic [XLEN-1:0]       r_abs2;
  logic                  r_negq;
  logic                  r_negr;
  logic [4:0]            r_cnt;
  logic [1:0][XLEN-1:0]  r_mp;

  rv32_mdu_req_t   w_req;
  logic            w_accept;
  logic            w_is_div;
  logic            w_sgn_div;
  logic            w_neg1;
  logic            w_neg2;
  logic            w_dz;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_s1;
  logic            w_s2;
  logic [63:0]     w_ma;
  logic [63:0]     w_mb;
  logic [63:0]     w_prod;
  logic [XLEN-1:0] w_mul_res;
  logic [XLEN-1:0] w_mul_fin;
  logic [XLEN-1:0] w_rem_out;
  logic [XLEN-1:0] w_quo_out;
  logic [XLEN-1:0] w_div_res;
  logic            w_is_rem;

  assign w_req = '{alu_op: req_alu_op, rs1: req_rs1,
                   rs2: req_rs2, rd: req_rd};

  assign w_accept = req_valid && (r_state == IDLE) && !flush
                    && is_mdu_op(req_alu_op);
  assign w_is_div = is_div_op(req_alu_op);

  assign w_sgn_div = (req_alu_op == ALU_OP_DIV)
                     || (req_alu_op == ALU_OP_REM);
  assign w_neg1 = w_sgn_div && req_rs1[XLEN-1];
  assign w_neg2 = w_sgn_div && req_rs2[XLEN-1];
  assign w_abs1 = w_neg1 ? -req_rs1 : req_rs1;
  assign w_abs2 = w_neg2 ? -req_rs2 : req_rs2;
  assign w_dz   = (req_rs2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic            w_early;
  logic [XLEN-1:0] w_early_data;
  logic            w_req_rem;
  assign w_req_rem = (req_alu_op == ALU_OP_REM)
                     || (req_alu_op == ALU_OP_REMU);
  assign w_early = w_dz || (w_abs2 > w_abs1);
  assign w_early_data = w_req_rem ? req_rs1
                      : (w_dz ? '1 : '0);
`endif

  // 33x33 signed product, sign-extended into a 64-bit multiply.
  assign w_s1 = (r_req.alu_op == ALU_OP_MULH)
                || (r_req.alu_op == ALU_OP_MULHSU);
  assign w_s2 = (r_req.alu_op == ALU_OP_MULH);
  assign w_ma = {{32{w_s1 & r_req.rs1[XLEN-1]}}, r_req.rs1};
  assign w_mb = {{32{w_s2 & r_req.rs2[XLEN-1]}}, r_req.rs2};
  assign w_prod = w_ma * w_mb;
  assign w_mul_res = (r_req.alu_op == ALU_OP_MUL)
                     ? w_prod[31:0] : w_prod[63:32];

  always_comb begin
    w_mul_fin = w_mul_res;
    if (MUL_LAT == 2) w_mul_fin = r_mp[0];
    else if (MUL_LAT >= 3) w_mul_fin = r_mp[1];
  end

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_abs2),
    .rem_out (w_rem_out),
    .quo_out (w_quo_out)
  );

  assign w_is_rem = (r_req.alu_op == ALU_OP_REM)
                    || (r_req.alu_op == ALU_OP_REMU);
  assign w_div_res = w_is_rem
                   ? (r_negr ? -w_rem_out : w_rem_out)
                   : (r_negq ? -w_quo_out : w_quo_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_resp       <= '0;
      r_resp_valid <= 1'b0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_abs2       <= '0;
      r_negq       <= 1'b0;
      r_negr       <= 1'b0;
      r_cnt        <= '0;
      r_mp         <= '0;
    end else if (flush) begin
      r_state      <= IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_req  <= w_req;
          r_rem  <= '0;
          r_quo  <= w_abs1;
          r_abs2 <= w_abs2;
          // Divide by zero keeps an all-ones quotient unsigned.
          r_negq <= (w_neg1 ^ w_neg2) && !w_dz;
          r_negr <= w_neg1;
          if (w_is_div) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_state      <= DONE;
              r_resp_valid <= 1'b1;
              r_resp       <= '{data: w_early_data, rd: req_rd};
            end else begin
              r_state <= DIV;
              r_cnt   <= 5'(MDU_DIV_ITERS - 1);
            end
`else
            r_state <= DIV;
            r_cnt   <= 5'(MDU_DIV_ITERS - 1);
`endif
          end else begin
            r_state <= MUL;
            r_cnt   <= 5'(MUL_LAT - 1);
          end
        end
        MUL: begin
          r_mp[0] <= w_mul_res;
          r_mp[1] <= r_mp[0];
          if (r_cnt == '0) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp       <= '{data: w_mul_fin, rd: r_req.rd};
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        DIV: begin
          r_rem <= w_rem_out;
          r_quo <= w_quo_out;
          if (r_cnt == '0) begin
            r_state      <= DONE;
            r_resp_valid <= 1'b1;
            r_resp       <= '{data: w_div_res, rd: r_req.rd};
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        DONE: if (resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp.data;
  assign resp_rd    = r_resp.rd;
  assign stall = w_accept
               || ((r_state != IDLE)
                   && !((r_state == DONE) && resp_ready));

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: driver pushes reference results,
// negedge monitor checks data, tag, latency, stall and handshake.
module tb_ex_muldiv_ctrl;
  import rv32_pkg::*;

  localparam int MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_alu_op = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        stall;

  ex_muldiv_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_alu_op (req_alu_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          issued;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   busy = 1'b0;
  int   due = 0;
  bit   hold_rr = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic bit is_m(input logic [5:0] op);
    return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
  endfunction

  function automatic logic [31:0] ref_res(input logic [5:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      ALU_OP_MUL:    begin p = 64'(ua * ub); return p[31:0]; end
      ALU_OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      ALU_OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      ALU_OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      ALU_OP_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(sa / sb);
        return p[31:0];
      end
      ALU_OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_OP_REM:    begin
        if (b == 0) return a;
        p = 64'(sa % sb);
        return p[31:0];
      end
      ALU_OP_REMU:   return (b == 0) ? a : a % b;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic int lat(input logic [5:0] op,
      input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit sg;
    if (op < ALU_OP_DIV) return 1 + MUL_LAT;
    sg = (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    ma = sg ? longint'($signed(a)) : longint'(a);
    mb = sg ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || mb > ma) return 1;
`endif
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic mon_step();
    bit ev, acc;
    ev  = busy && (cyc >= due);
    acc = req_valid && !busy && !flush && is_m(req_alu_op);
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    chk("stall", 32'(stall), 32'(acc || (busy && !(ev && resp_ready))));
    if (resp_valid) begin
      if (!have_cur) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: data %h rd %0d (cycle %0d)",
                   resp_data, resp_rd, cyc);
        end else begin
          cur = q.pop_front();
          have_cur = 1'b1;
          chk("latency", 32'(cyc), 32'(cur.issued + lat(cur.op, cur.a, cur.b)));
        end
      end
      if (have_cur) begin
        chk("resp_data", resp_data, cur.data);
        chk("resp_rd", 32'(resp_rd), 32'(cur.rd));
      end
    end
    if (flush) begin
      busy = 1'b0;
      have_cur = 1'b0;
      q.delete();
    end else begin
      if (ev && resp_ready) begin
        busy = 1'b0;
        have_cur = 1'b0;
      end
      if (acc) begin
        busy = 1'b1;
        due = cyc + lat(req_alu_op, req_rs1, req_rs2);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) mon_step();
  end

  function automatic bit rr_val();
    return hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
  endfunction

  task automatic drive(input bit v, input logic [5:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
      input bit fl, input bit rr, output bit pushed);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_alu_op = op;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    flush      = fl;
    resp_ready = rr;
    pushed = v && !fl && !busy && is_m(op);
    if (pushed) q.push_back('{ref_res(op, a, b), rd, op, a, b, cyc});
  endtask

  task automatic idle(input int n);
    bit p;
    repeat (n) drive(1'b0, '0, '0, '0, '0, 1'b0, rr_val(), p);
  endtask

  task automatic do_flush();
    bit p;
    drive(1'b0, '0, '0, '0, '0, 1'b1, rr_val(), p);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] rd);
    bit p;
    int g;
    p = 1'b0;
    g = 0;
    while (!p && g < 400) begin
      drive(1'b1, op, a, b, rd, 1'b0, rr_val(), p);
      g++;
    end
    if (!p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: op %h never accepted", op);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || q.size() != 0) && g < 400) begin
      idle(1);
      g++;
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles", g);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit p;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    issue(ALU_OP_MULH, 32'hFFFF_FFFF, 32'd2, 5'd1);
    issue(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd2);
    issue(ALU_OP_MUL, 32'hFFFF_FFF9, 32'd3, 5'd3);
    issue(ALU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    issue(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(ALU_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
    issue(ALU_OP_DIVU, 32'd100, 32'd0, 5'd7);
    issue(ALU_OP_REMU, 32'd100, 32'd0, 5'd8);
    issue(ALU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    issue(ALU_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    issue(ALU_OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd11);
    issue(ALU_OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd12);
    issue(ALU_OP_DIVU, 32'd3, 32'd10, 5'd13);
    issue(ALU_OP_REM, 32'd3, 32'hFFFF_FFF6, 5'd14);
    wait_idle();

    // Flush a divide ten cycles in, then a multiply right behind it.
    issue(ALU_OP_DIV, 32'd1000, 32'd7, 5'd15);
    idle(9);
    do_flush();
    issue(ALU_OP_MUL, 32'd1234, 32'd5678, 5'd16);
    wait_idle();

    // Back-pressure: result must sit stable while resp_ready is low.
    hold_rr = 1'b1;
    issue(ALU_OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17);
    idle(8);
    hold_rr = 1'b0;
    wait_idle();

    // Neither a non-M op nor an M op under flush may be accepted.
    drive(1'b1, ALU_OP_ADD, 32'd1, 32'd2, 5'd18, 1'b0, 1'b1, p);
    drive(1'b1, ALU_OP_DIV, 32'd9, 32'd3, 5'd19, 1'b1, 1'b1, p);
    idle(3);

    for (int i = 0; i < 200; i++) begin
      issue(6'(ALU_OP_MUL + 6'($urandom_range(0, 7))), rnd32(), rnd32(),
            5'($urandom_range(0, 31)));
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 40));
        do_flush();
      end
    end
    wait_idle();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle M-extension sequencer for the in-order single-issue pipeline.
- The execute stage hands any MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op to this block.
- The block stalls the front of the pipeline until a single 64-bit product or a 32-iteration restoring divide completes.
- The result is returned on a valid/ready response channel to the EX->MEM write-back path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- MUL_LAT, 1, cycles spent in MUL state (1..3); product is pipelined through MUL_LAT registers.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an M-op
- req_ready  out  1  block can accept a request
- req_alu_op  in  6  ALU_OP_* code from rv32_pkg
- req_rs1  in  32  forwarded rs1 value
- req_rs2  in  32  forwarded rs2 value
- req_rd  in  5  destination register tag
- flush  in  1  branch/jump redirect; kills any in-flight op
- resp_valid  out  1  result available
- resp_ready  in  1  write-back path consumes result
- resp_data  out  32  result
- resp_rd  out  5  destination tag of result
- stall  out  1  hold IF/ID/EX

Behaviour:
Reset (async, rst_n=0) outputs and state:
- state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, stall=0.
- Counter and operand registers are cleared.

Acceptance:
- A request is accepted when req_valid && req_ready && !flush && req_alu_op is one of the 8 M-ops.
- A non-M op is never accepted and produces no response.
- req_ready = (state==IDLE).

States:
- IDLE: on accept, latch op, rd, rs1, rs2, |rs1|, |rs2|, quotient sign and remainder sign.
  - MUL-class op -> MUL.
  - DIV-class op -> DIV, counter=31.
- MUL: run MUL_LAT cycles, then -> DONE.
  - MUL: low 32 bits of the product.
  - MULH: signed x signed, high 32 bits.
  - MULHSU: signed x unsigned, high 32 bits.
  - MULHU: unsigned x unsigned, high 32 bits.
  - Products are formed as 33x33 signed with per-op sign extension.
- DIV: one restoring step per cycle (shift remainder, trial-subtract divisor, set quotient bit).
  - Counter decrements; after the counter==0 step -> DONE. That is exactly 32 DIV cycles.
- DONE: resp_valid=1; resp_data/resp_rd are held stable until resp_ready.
  - On resp_ready -> IDLE (back-to-back accept is possible the following cycle).

Latency (request accepted at cycle N):
- MUL: resp_valid first at N+1+MUL_LAT.
- DIV: resp_valid first at N+33.

Stall:
- stall = (state!=IDLE) && !(state==DONE && resp_ready).
- stall is also asserted combinationally in the accept cycle.

Sign fixup (DIV/REM):
- Quotient is negated if operand signs differ.
- Remainder takes the dividend's sign.

Boundaries:
- Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush in any state: -> IDLE next cycle. resp_valid drops, no response is issued, stall drops next cycle.
- flush together with req_valid: the request is not accepted.
- resp_ready held low: the block stays in DONE, stall stays 1, and outputs stay stable.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in IDLE, a divide with rs2==0, or with unsigned |rs2|>|rs1|, skips DIV and enters DONE directly.
  - resp_valid at N+1.
  - Divide by zero gives the values listed above.
  - The other case gives quotient 0 and remainder rs1.
- Undefined: every divide takes the full 32 iterations. Results are identical; only latency differs.

Decomposition:
- rv32_pkg gains:
  - mdu_state_t enum {IDLE, MUL, DIV, DONE}.
  - rv32_mdu_req_t struct (alu_op, rs1, rs2, rd).
  - rv32_mdu_resp_t struct (data, rd).
  - MDU_DIV_ITERS=32.
- Existing ALU_OP_* codes are reused.
- One sub-module, mdu_div_step: combinational single restoring iteration (rem_in, quo_in, divisor -> rem_out, quo_out). It is instantiated once inside the sequential loop.

Test Plan:
- MULH rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> resp_data=0xFFFFFFFF at N+2 (MUL_LAT=1); MULHU same operands -> 0x00000001.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD at N+33; REM same operands -> 0xFFFFFFFF; stall high N..N+32.
- DIVU rs1=100, rs2=0 -> 0xFFFFFFFF; REMU -> 100; latency N+33 without MULDIV_EARLY_OUT_EN, N+1 with it.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Start DIV, assert flush at N+10 -> IDLE at N+11, resp_valid never rises, stall=0 at N+11; new MUL accepted at N+11 completes normally.
- Hold resp_ready=0 for 5 cycles in DONE -> resp_data/resp_rd stable, stall=1, req_ready=0; release -> IDLE next cycle.
